// File: rtl/cpu_pkg.sv
// Shared CPU definitions: microcycle encodings, default bus widths and the
// RAM arbiter state type.
package cpu_pkg;

  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_bus_arbiter.sv
// Shares the data RAM between the CPU core and the host debug port. The CPU
// always wins; host accesses are slotted into cycles 0..WIN_LAST.
module ram_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WIN_LAST = 3
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [2:0]        cycle,
  input  logic              cpuRamWe,
  input  logic              cpuRamRe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuDin,
  output logic [DATA_W-1:0] cpuDout,
  input  logic              hostReq,
  input  logic              hostWr,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWdata,
  output logic              hostAck,
  output logic [DATA_W-1:0] hostRdata,
  output logic              hostBusy,
  output logic              ramWe,
  output logic              ramRe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramDin,
  input  logic [DATA_W-1:0] ramDout,
  output logic [7:0]        conflictCnt,
  output arb_state_t        dbgState
);

  localparam logic [2:0] WIN_LAST_C = 3'(WIN_LAST);

  // Host handshake: hostReq is a request sampled only while idle (no ready
  // signal; a request while busy is dropped). hostBusy covers the whole
  // transaction and hostAck is a single-clock completion pulse.
  arb_state_t        state_q, state_d;
  logic              h_wr_q, h_wr_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d;
  logic [DATA_W-1:0] h_wdata_q, h_wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic cpu_strobe;
  logic host_window;
  logic grant;

  assign cpu_strobe  = cpuRamWe | cpuRamRe;
  assign host_window = (cycle <= WIN_LAST_C);
  assign grant       = (state_q == PEND) & host_window & ~cpu_strobe;

  always_comb begin
    ramWe   = cpuRamWe;
    ramRe   = cpuRamRe;
    ramAddr = cpuAddr;
    ramDin  = cpuDin;
    if (grant) begin
      ramWe   = h_wr_q;
      ramRe   = ~h_wr_q;
      ramAddr = h_addr_q;
      ramDin  = h_wdata_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    h_wr_d    = h_wr_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (hostReq) begin
          h_wr_d    = hostWr;
          h_addr_d  = hostAddr;
          h_wdata_d = hostWdata;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (grant) begin
          if (h_wr_q) begin
            ack_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        // The registered RAM presents the granted read this clock.
        rdata_d = ramDout;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Diagnostic only: CPU strobes outside X1..X3 saturate at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (cpu_strobe && (cycle <= CYC_M2) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      h_wr_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_wr_q    <= h_wr_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpuDout     = ramDout;
  assign hostAck     = ack_q;
  assign hostRdata   = rdata_q;
  assign hostBusy    = (state_q != IDLE);
  assign conflictCnt = cnt_q;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: table vectors, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ram_bus_arbiter;
  import cpu_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 4;
  localparam int WL  = 3;
  localparam int NR  = 1600;
  localparam int NRP = NR + 64;

  logic          clk = 1'b0;
  logic          rstN;
  logic [2:0]    cycle;
  logic          cpuRamWe, cpuRamRe;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuDin, cpuDout;
  logic          hostReq, hostWr;
  logic [AW-1:0] hostAddr;
  logic [DW-1:0] hostWdata;
  logic          hostAck;
  logic [DW-1:0] hostRdata;
  logic          hostBusy;
  logic          ramWe, ramRe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDin, ramDout;
  logic [7:0]    conflictCnt;
  arb_state_t    dbgState;

  int checks = 0;
  int errors = 0;

  ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WIN_LAST(WL)) dut (
    .clk(clk), .rstN(rstN), .cycle(cycle),
    .cpuRamWe(cpuRamWe), .cpuRamRe(cpuRamRe), .cpuAddr(cpuAddr),
    .cpuDin(cpuDin), .cpuDout(cpuDout),
    .hostReq(hostReq), .hostWr(hostWr), .hostAddr(hostAddr),
    .hostWdata(hostWdata), .hostAck(hostAck), .hostRdata(hostRdata),
    .hostBusy(hostBusy),
    .ramWe(ramWe), .ramRe(ramRe), .ramAddr(ramAddr), .ramDin(ramDin),
    .ramDout(ramDout), .conflictCnt(conflictCnt), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // registered RAM: read data valid the clock after ramRe
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramDin;
    if (ramRe) ram_q <= mem[ramAddr];
  end
  assign ramDout = ram_q;

  // scoreboard
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle = cycle + 3'd1;
  endtask

  task automatic to_cycle(input logic [2:0] c);
    for (int k = 0; k < 8 && cycle != c; k++) tick();
  endtask

  task automatic do_reset();
    rstN     = 1'b0;
    hostReq  = 1'b0;
    cpuRamWe = 1'b0;
    cpuRamRe = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  typedef struct {
    logic [2:0]    cyc;
    logic          we, re;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          req, hwr;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hdata;
    logic          e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_busy;
  } vec_t;

  vec_t vecs[14];

  // random-phase stimulus patterns and reference model state
  logic          p_we [NRP];
  logic          p_re [NRP];
  logic [AW-1:0] p_a  [NRP];
  logic [DW-1:0] p_d  [NRP];
  logic [DW-1:0] shadow [16];

  function automatic int find_grant(input int from);
    for (int t = from + 1; t < NRP; t++)
      if ((t % 8) <= WL && !(p_we[t] | p_re[t])) return t;
    return NRP;
  endfunction

  initial begin
    int n;
    bit mid_done;
    int m_l, m_g, ack_t, idle_from, cnt_m, pre_k;
    logic m_wr, ack_rd, dout_known, rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, last_rdata, exp_dout, next_dout, popped;

    cycle = 3'd5; cpuRamWe = 1'b0; cpuRamRe = 1'b0; cpuAddr = '0; cpuDin = '0;
    hostReq = 1'b0; hostWr = 1'b0; hostAddr = '0; hostWdata = '0; rstN = 1'b0;

    // reset state, with RAM following the CPU during reset
    @(negedge clk);
    cpuRamWe = 1'b1; cpuAddr = 12'h123; cpuDin = 4'h6;
    #1;
    chk("rst_ack", hostAck, 0);
    chk("rst_busy", hostBusy, 0);
    chk("rst_rdata", hostRdata, 0);
    chk("rst_cnt", conflictCnt, 0);
    chk("rst_state", dbgState, IDLE);
    chk("rst_mux", {ramWe, ramRe, ramAddr, ramDin}, {1'b1, 1'b0, 12'h123, 4'h6});
    cpuRamWe = 1'b0; cpuAddr = '0; cpuDin = '0;
    do_reset();

    // table vectors: consecutive clocks, state carries between rows
    //          cyc we re addr    din  req hwr haddr   hdata ewe ere eaddr   edin busy
    vecs[0]  = '{3'd5, 0, 1, 12'h010, 4'h0, 0, 0, 12'h000, 4'h0, 0, 1, 12'h010, 4'h0, 0};
    vecs[1]  = '{3'd6, 1, 0, 12'h011, 4'h7, 1, 1, 12'h222, 4'hA, 1, 0, 12'h011, 4'h7, 0};
    vecs[2]  = '{3'd7, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1};
    vecs[3]  = '{3'd0, 0, 1, 12'h033, 4'h0, 0, 0, 12'h000, 4'h0, 0, 1, 12'h033, 4'h0, 1};
    vecs[4]  = '{3'd1, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1, 0, 12'h222, 4'hA, 1};
    vecs[5]  = '{3'd2, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0};
    vecs[6]  = '{3'd3, 1, 0, 12'h044, 4'h5, 1, 0, 12'h055, 4'h0, 1, 0, 12'h044, 4'h5, 0};
    vecs[7]  = '{3'd4, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1};
    vecs[8]  = '{3'd5, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1};
    vecs[9]  = '{3'd6, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1};
    vecs[10] = '{3'd7, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1};
    vecs[11] = '{3'd0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 1, 12'h055, 4'h0, 1};
    vecs[12] = '{3'd1, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 1};
    vecs[13] = '{3'd2, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0, 0};
    for (int i = 0; i < 14; i++) begin
      cycle = vecs[i].cyc; cpuRamWe = vecs[i].we; cpuRamRe = vecs[i].re;
      cpuAddr = vecs[i].addr; cpuDin = vecs[i].din; hostReq = vecs[i].req;
      hostWr = vecs[i].hwr; hostAddr = vecs[i].haddr; hostWdata = vecs[i].hdata;
      #1;
      chk($sformatf("vec%0d_we", i), ramWe, vecs[i].e_we);
      chk($sformatf("vec%0d_re", i), ramRe, vecs[i].e_re);
      chk($sformatf("vec%0d_addr", i), ramAddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_din", i), ramDin, vecs[i].e_din);
      chk($sformatf("vec%0d_busy", i), hostBusy, vecs[i].e_busy);
      tick();
    end
    cpuRamWe = 1'b0; cpuRamRe = 1'b0; cpuAddr = '0; cpuDin = '0; hostReq = 1'b0;
    #1 chk("vec_cnt", conflictCnt, 2);

    // host write latched at X3, granted at A1, CPU reads it back in X2
    do_reset();
    to_cycle(3'd7);
    hostReq = 1'b1; hostWr = 1'b1; hostAddr = 12'h0A5; hostWdata = 4'h9;
    #1 chk("wr_latch_busy", hostBusy, 0);
    tick(); hostReq = 1'b0;
    #1;
    chk("wr_grant", {ramWe, ramRe, ramAddr, ramDin}, {1'b1, 1'b0, 12'h0A5, 4'h9});
    chk("wr_grant_cyc", cycle, 0);
    chk("wr_grant_ack", hostAck, 0);
    tick();
    #1; chk("wr_ack", hostAck, 1); chk("wr_ack_busy", hostBusy, 0);
    tick();
    #1 chk("wr_ack_pulse", hostAck, 0);
    to_cycle(3'd6); cpuRamRe = 1'b1; cpuAddr = 12'h0A5;
    tick(); cpuRamRe = 1'b0;
    #1 chk("wr_cpu_readback", cpuDout, 4'h9);

    // host read latched at X1, no host strobes in X1..X3, acked at A3
    to_cycle(3'd6); cpuRamWe = 1'b1; cpuAddr = 12'h1F0; cpuDin = 4'h3;
    tick(); cpuRamWe = 1'b0; cpuAddr = '0; cpuDin = '0;
    to_cycle(3'd5);
    hostReq = 1'b1; hostWr = 1'b0; hostAddr = 12'h1F0;
    #1 chk("rd_x_strobe5", {ramWe, ramRe}, 0);
    tick(); hostReq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1; chk("rd_x_strobe", {ramWe, ramRe}, 0); chk("rd_x_busy", hostBusy, 1);
      tick();
    end
    #1 chk("rd_grant", {ramWe, ramRe, ramAddr}, {1'b0, 1'b1, 12'h1F0});
    tick();
    #1; chk("rd_wait_ack", hostAck, 0); chk("rd_wait_busy", hostBusy, 1);
    tick();
    #1; chk("rd_ack", hostAck, 1); chk("rd_data", hostRdata, 4'h3); chk("rd_ack_cyc", cycle, 2);

    // deferred grant: CPU strobe at A2 pushes the host read to A3
    to_cycle(3'd0);
    hostReq = 1'b1; hostWr = 1'b0; hostAddr = 12'h0A5;
    tick(); hostReq = 1'b0; cpuRamRe = 1'b1; cpuAddr = 12'h100;
    #1 chk("def_cpu_wins", {ramRe, ramAddr}, {1'b1, 12'h100});
    tick(); cpuRamRe = 1'b0; cpuAddr = '0;
    #1; chk("def_grant", {ramRe, ramAddr}, {1'b1, 12'h0A5}); chk("def_cnt", conflictCnt, 1);
    tick(); tick();
    #1; chk("def_ack", hostAck, 1); chk("def_data", hostRdata, 4'h9);

    // window miss: latched at M1, granted at the next A1
    to_cycle(3'd3);
    hostReq = 1'b1; hostWr = 1'b1; hostAddr = 12'h0C0; hostWdata = 4'h5;
    #1 chk("miss_latch_we", ramWe, 0);
    tick(); hostReq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; chk("miss_busy", hostBusy, 1); chk("miss_no_we", ramWe, 0);
      tick();
    end
    #1 chk("miss_grant", {ramWe, ramAddr, ramDin, cycle}, {1'b1, 12'h0C0, 4'h5, 3'd0});
    tick();
    #1 chk("miss_ack", hostAck, 1);

    // reset in RDWAIT drops the read with no ack
    to_cycle(3'd7);
    hostReq = 1'b1; hostWr = 1'b0; hostAddr = 12'h0C0;
    tick(); hostReq = 1'b0;
    #1 chk("rr_grant", ramRe, 1);
    tick();
    #1 chk("rr_busy", hostBusy, 1);
    rstN = 1'b0;
    #1;
    chk("rr_busy0", hostBusy, 0); chk("rr_ack0", hostAck, 0);
    chk("rr_rdata0", hostRdata, 0); chk("rr_cnt0", conflictCnt, 0);
    tick(); rstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_no_ack", hostAck, 0);
      tick();
    end

    // saturation: 300 out-of-window CPU strobes
    n = 0; mid_done = 0;
    cpuRamRe = 1'b1; cpuAddr = '0;
    while (n < 300) begin
      #1;
      if (n == 100 && !mid_done) begin
        chk("sat_mid", conflictCnt, 100);
        mid_done = 1;
      end
      if (cycle <= 3'd4) n++;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      #1 chk("sat_hold", conflictCnt, 255);
      tick();
    end
    cpuRamRe = 1'b0;

    // randomized run against the reference model
    pre_k = 0;
    for (int t = 0; t < NRP; t++) begin
      p_we[t] = 1'b0; p_re[t] = 1'b0;
      p_a[t] = 12'($urandom_range(0, 15)); p_d[t] = 4'($urandom_range(0, 15));
      if (t < 128) begin
        if ((t % 8) >= 5) begin
          p_we[t] = 1'b1; p_a[t] = 12'(pre_k % 16); pre_k++;
        end
      end else if ((t % 8) >= 5) begin
        n = $urandom_range(0, 5);
        p_we[t] = (n == 0); p_re[t] = (n == 1 || n == 2);
      end else begin
        p_re[t] = ($urandom_range(0, 5) == 0);
      end
    end

    do_reset();
    to_cycle(3'd0);
    m_l = -1; m_g = -1; ack_t = -1; idle_from = 0; cnt_m = 0;
    m_wr = 1'b0; ack_rd = 1'b0; m_addr = '0; m_data = '0;
    last_rdata = '0; exp_dout = '0; dout_known = 1'b0;
    for (int t = 0; t < NR; t++) begin
      cpuRamWe = p_we[t]; cpuRamRe = p_re[t]; cpuAddr = p_a[t]; cpuDin = p_d[t];
      hostReq = 1'b0;
      if (t >= 128 && t < NR - 64 && $urandom_range(0, 3) == 0) begin
        hostReq = 1'b1; hostWr = 1'($urandom_range(0, 1));
        hostAddr = 12'($urandom_range(0, 15)); hostWdata = 4'($urandom_range(0, 15));
      end
      if (t == ack_t && ack_rd) begin
        popped = exp_q.pop_front();
        last_rdata = popped;
      end
      #1;
      chk("rnd_busy", hostBusy, (t > m_l && t < ack_t));
      chk("rnd_ack", hostAck, (t == ack_t));
      chk("rnd_rdata", hostRdata, last_rdata);
      chk("rnd_cnt", conflictCnt, cnt_m);
      if (dout_known) chk("rnd_cpudout", cpuDout, exp_dout);
      if (t == m_g)
        chk("rnd_host_ram", {ramWe, ramRe, ramAddr, ramDin}, {m_wr, ~m_wr, m_addr, m_data});
      else
        chk("rnd_cpu_ram", {ramWe, ramRe, ramAddr, ramDin}, {p_we[t], p_re[t], p_a[t], p_d[t]});
      // end-of-clock model update
      rd = 1'b0; next_dout = '0;
      if (t == m_g) begin
        if (m_wr) shadow[m_addr[3:0]] = m_data;
        else begin
          exp_q.push_back(shadow[m_addr[3:0]]);
          next_dout = shadow[m_addr[3:0]]; rd = 1'b1;
        end
      end else begin
        if (p_we[t]) shadow[p_a[t][3:0]] = p_d[t];
        if (p_re[t]) begin next_dout = shadow[p_a[t][3:0]]; rd = 1'b1; end
      end
      if (rd) begin exp_dout = next_dout; dout_known = 1'b1; end
      if ((t % 8) <= 4 && (p_we[t] || p_re[t]) && cnt_m < 255) cnt_m++;
      if (hostReq && t >= idle_from) begin
        m_l = t; m_wr = hostWr; m_addr = hostAddr; m_data = hostWdata;
        m_g = find_grant(t);
        ack_t = m_g + (hostWr ? 1 : 2);
        ack_rd = ~hostWr;
        idle_from = ack_t;
      end
      tick();
    end
    chk("rnd_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Shares the single data RAM between the CPU core and a host debug port. The CPU owns the RAM during X1..X3 (`cycle` 5..7). Host reads and writes are slotted into the A1..M1 window (`cycle` 0..3), so a running program never stalls or sees contention. The block sits between `cpuTop`'s decoder/register-pair address path and the `ram` instance.

## Interface
Parameters:
- `ADDR_W`, 12, RAM address width ({bankSel, pair}).
- `DATA_W`, 4, nibble width.
- `WIN_LAST`, 3, last `cycle` value in which a host access may be granted. Legal range 0..3.

Ports:
- `clk`  in  1  system clock; one clock only.
- `rstN`  in  1  reset; asynchronous, active-low.
- `cycle`  in  3  microcycle index: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- `cpuRamWe`, `cpuRamRe`  in  1  CPU write/read strobes.
- `cpuAddr`  in  ADDR_W  CPU address.
- `cpuDin`  in  DATA_W  CPU write data (ACC).
- `cpuDout`  out  DATA_W  RAM read data to CPU.
- `hostReq`  in  1  host request; sampled only in IDLE.
- `hostWr`  in  1  1 = write, 0 = read; latched with `hostReq`.
- `hostAddr`  in  ADDR_W  host address; latched with `hostReq`.
- `hostWdata`  in  DATA_W  host write data; latched with `hostReq`.
- `hostAck`  out  1  one-clock completion pulse.
- `hostRdata`  out  DATA_W  read result; holds until the next read completes.
- `hostBusy`  out  1  high from request latch until `hostAck`.
- `ramWe`, `ramRe`  out  1  RAM strobes.
- `ramAddr`  out  ADDR_W  RAM address.
- `ramDin`  out  DATA_W  RAM write data.
- `ramDout`  in  DATA_W  RAM read data. The RAM is registered: data is valid the clock after `ramRe`.
- `conflictCnt`  out  8  saturating count of out-of-window CPU strobes.

## Operation
- `cpuStrobe = cpuRamWe | cpuRamRe`. `hostWindow = (cycle <= WIN_LAST)`.
- `cpuDout = ramDout` (combinational passthrough).
- **RAM mux:**
  - When `grant` is high, the RAM is driven from the latched host fields: `ramWe = hWr`, `ramRe = !hWr`.
  - Otherwise the CPU signals pass through combinationally.
  - `grant = (state == PEND) & hostWindow & !cpuStrobe`. The CPU always wins.
- **FSM states** (`hostBusy = state != IDLE`):
  - IDLE: if `hostReq`, latch `hostWr`, `hostAddr`, `hostWdata`, then go to PEND.
  - PEND: on `grant`, a write goes to IDLE and sets `hostAck` on the next clock; a read goes to RDWAIT. Without `grant`, stay in PEND.
  - RDWAIT: `hostRdata <= ramDout`, set `hostAck` on the next clock, go to IDLE.
- `hostAck` is registered and high for exactly one clock. A `hostReq` seen while the FSM is not in IDLE is ignored (not queued).
- **conflictCnt:** increments on every clock with `cpuStrobe & (cycle <= 4)`. It saturates at 255 and never wraps. This is a diagnostic only and does not change arbitration.
- **Reset:** on assertion, even mid-transaction:
  - state = IDLE, `hostAck = 0`, `hostRdata = 0`, `conflictCnt = 0`, latched host fields = 0.
  - The pending request is dropped and no ack is issued.
  - The RAM outputs then follow the CPU inputs.

## Timing
- **Write latency:** grant clock G; `hostAck` is high in G+1.
- **Read latency:** grant clock G; `ramDout` is valid in G+1 and captured at the end of G+1; `hostAck` and `hostRdata` are valid in G+2.
- **Window guarantee:** with `WIN_LAST <= 3`, the RDWAIT clock falls at `cycle <= 4`, so host activity never overlaps X1..X3.
- **Best case:** a request latched in X3 (`cycle` 7) is granted at A1, and a read is acked at A3.
- **Worst case:** a request latched at `cycle` WIN_LAST+1 waits until the next A1, which is ≤ 8 clocks of PEND.
- **Back-to-back requests:** `hostReq` asserted in the `hostAck` clock is accepted, since the FSM is already in IDLE.
- **CPU strobe in the host window while in PEND:** the grant is deferred clock by clock and `conflictCnt` increments. The deferred access retries on the next in-window clock without a CPU strobe.
- **CPU strobe during RDWAIT:** the CPU drives the RAM; the capture still takes the prior-clock read data.

## Structure
- Shared package `cpu_pkg`:
  - microcycle encodings `CYC_A1..CYC_X3`
  - `ADDR_W` / `DATA_W` defaults
  - FSM state typedef `arb_state_t {IDLE, PEND, RDWAIT}`
- Single module, no sub-modules. The saturating counter stays inline.
- Instantiated in `cpuTop` between the decoder strobes and `ram`.

## Test plan
- **Host write:** reset, host write addr 0x0A5, data 0x9 latched at `cycle` 7 → `ramWe` = 1 with addr 0x0A5 at `cycle` 0; `hostAck` at `cycle` 1; a CPU read of 0x0A5 in X2 returns 0x9.
- **Host read:** preload 0x3 at addr 0x1F0, host read latched at `cycle` 5 → grant at the next `cycle` 0; `hostAck` at `cycle` 2 with `hostRdata` = 0x3; no RAM strobe from the host during `cycle` 5..7.
- **Deferred grant:** host read pending while the CPU asserts `cpuRamRe` at `cycle` 1 → no grant at `cycle` 1, grant at `cycle` 2, `conflictCnt` = 1.
- **Window miss:** request latched at `cycle` 3 with `WIN_LAST` = 3 and no CPU strobe → grant at the same-window `cycle` 3 is impossible (latch clock), so the grant lands at the next `cycle` 0; `hostBusy` stays high meanwhile.
- **Reset mid-read:** assert `rstN` = 0 in RDWAIT → `hostAck` never pulses; `hostRdata` = 0, `hostBusy` = 0, `conflictCnt` = 0.
- **Saturation:** force 300 out-of-window CPU strobes → `conflictCnt` = 255 and holds.
